// File: rtl/qam_ctrl_pkg.sv
// qam_ctrl_pkg: shared state encoding, frame index width and default LFSR seed table
package qam_ctrl_pkg;
    localparam int FIDX_W = 4;
    typedef enum logic [2:0] {S_IDLE, S_RST, S_LOAD, S_RUN, S_NEXT, S_DONE} state_t;
    localparam logic [6:0] DEFAULT_SEEDS [0:15] = '{
        7'b1010101, 7'b0101010, 7'b1110001, 7'b0001110,
        7'b1001101, 7'b0110010, 7'b1100110, 7'b0011001,
        7'b1000001, 7'b0101010, 7'b1011101, 7'b1101110,
        7'b1000101, 7'b1100010, 7'b1010110, 7'b0011111
    };
endpackage

// File: rtl/qam_frame_ctrl_if.sv
// qam_frame_ctrl_if: control/status bundle between the frame sequencer and its user.
// QAM_CTRL_SEED_WR_EN adds the seed-table write port.
interface qam_frame_ctrl_if import qam_ctrl_pkg::*; #(
    parameter int SEED_W = 7,
    parameter int SYM_W  = 7
);
    logic              start, abort, valid_out;
    logic              dp_reset, lfsr_reset, lfsr_load, busy, done, frame_end, timeout_err;
    logic [SEED_W-1:0] lfsr_seed;
    logic [FIDX_W-1:0] frame_idx;
    logic [SYM_W-1:0]  sym_cnt;
`ifdef QAM_CTRL_SEED_WR_EN
    logic              seed_we;
    logic [FIDX_W-1:0] seed_waddr;
    logic [SEED_W-1:0] seed_wdata;
    modport master (output start, abort, valid_out, seed_we, seed_waddr, seed_wdata,
                    input dp_reset, lfsr_reset, lfsr_load, lfsr_seed, busy, done,
                          frame_idx, sym_cnt, frame_end, timeout_err);
    modport slave  (input start, abort, valid_out, seed_we, seed_waddr, seed_wdata,
                    output dp_reset, lfsr_reset, lfsr_load, lfsr_seed, busy, done,
                           frame_idx, sym_cnt, frame_end, timeout_err);
`else
    modport master (output start, abort, valid_out,
                    input dp_reset, lfsr_reset, lfsr_load, lfsr_seed, busy, done,
                          frame_idx, sym_cnt, frame_end, timeout_err);
    modport slave  (input start, abort, valid_out,
                    output dp_reset, lfsr_reset, lfsr_load, lfsr_seed, busy, done,
                           frame_idx, sym_cnt, frame_end, timeout_err);
`endif
endinterface

// File: rtl/qam_seed_table.sv
// qam_seed_table: 16-entry LFSR seed table with asynchronous read.
// QAM_CTRL_SEED_WR_EN makes it a writable register file; otherwise it is the constant default.
module qam_seed_table import qam_ctrl_pkg::*; #(
    parameter int SEED_W = 7
) (
`ifdef QAM_CTRL_SEED_WR_EN
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [FIDX_W-1:0] i_waddr,
    input  logic [SEED_W-1:0] i_wdata,
`endif
    input  logic [FIDX_W-1:0] i_raddr,
    output logic [SEED_W-1:0] o_rdata
);
`ifdef QAM_CTRL_SEED_WR_EN
    logic [SEED_W-1:0] r_mem [0:15];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= SEED_W'(DEFAULT_SEEDS[i]);
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
    assign o_rdata = r_mem[i_raddr];
`else
    assign o_rdata = SEED_W'(DEFAULT_SEEDS[i_raddr]);
`endif
endmodule

// File: rtl/qam_frame_ctrl.sv
// qam_frame_ctrl: per-frame reset/seed-load/symbol-count sequencer for the QAM transmit chain.
// QAM_CTRL_SEED_WR_EN enables idle-time writes to the seed table.
module qam_frame_ctrl #(
    parameter int NUM_FRAMES     = 16,
    parameter int SYMS_PER_FRAME = 64,
    parameter int SEED_W         = 7,
    parameter int TIMEOUT        = 4096
) (
    input logic                clk,
    input logic                reset,
    qam_frame_ctrl_if.slave    bus
);
    import qam_ctrl_pkg::*;
    localparam int SYM_W = $clog2(SYMS_PER_FRAME + 1);
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t            r_state;
    logic              r_dp_reset, r_lfsr_reset, r_lfsr_load, r_busy, r_done, r_frame_end, r_timeout_err;
    logic [FIDX_W-1:0] r_frame_idx;
    logic [SYM_W-1:0]  r_sym_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              w_last_sym, w_wd_exp, w_last_frame;

    assign w_last_sym   = r_sym_cnt == SYM_W'(SYMS_PER_FRAME - 1);
    assign w_wd_exp     = r_wd == WD_W'(TIMEOUT - 1);
    assign w_last_frame = r_frame_idx == FIDX_W'(NUM_FRAMES - 1);

    qam_seed_table #(.SEED_W(SEED_W)) u_seeds (
`ifdef QAM_CTRL_SEED_WR_EN
        .clk     (clk),
        .reset   (reset),
        .i_we    (bus.seed_we & ~r_busy),
        .i_waddr (bus.seed_waddr),
        .i_wdata (bus.seed_wdata),
`endif
        .i_raddr (r_frame_idx),
        .o_rdata (bus.lfsr_seed)
    );

    // Outputs are registered by assigning the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dp_reset    <= 1'b1;
            r_lfsr_reset  <= 1'b1;
            r_lfsr_load   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_end   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_frame_idx   <= '0;
            r_sym_cnt     <= '0;
            r_wd          <= '0;
        end else if (bus.abort) begin
            r_state      <= S_IDLE;
            r_dp_reset   <= 1'b1;
            r_lfsr_reset <= 1'b1;
            r_lfsr_load  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            r_lfsr_load <= 1'b0;
            r_done      <= 1'b0;
            r_frame_end <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_state       <= S_RST;
                    r_busy        <= 1'b1;
                    r_frame_idx   <= '0;
                    r_timeout_err <= 1'b0;
                    r_sym_cnt     <= '0;
                    r_wd          <= '0;
                end
                S_RST: begin
                    r_state      <= S_LOAD;
                    r_dp_reset   <= 1'b0;
                    r_lfsr_reset <= 1'b0;
                    r_lfsr_load  <= 1'b1;
                    r_sym_cnt    <= '0;
                    r_wd         <= '0;
                end
                S_LOAD: r_state <= S_RUN;
                S_RUN: begin
                    // A symbol arriving on the expiry cycle wins over the timeout.
                    if (bus.valid_out) begin
                        r_wd      <= '0;
                        r_sym_cnt <= r_sym_cnt == SYM_W'(SYMS_PER_FRAME) ? r_sym_cnt : r_sym_cnt + 1'b1;
                        if (w_last_sym) begin
                            r_state     <= S_NEXT;
                            r_frame_end <= 1'b1;
                        end
                    end else if (w_wd_exp) begin
                        r_state       <= S_NEXT;
                        r_frame_end   <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_last_frame) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_RST;
                        r_frame_idx  <= r_frame_idx + 1'b1;
                        r_dp_reset   <= 1'b1;
                        r_lfsr_reset <= 1'b1;
                        r_sym_cnt    <= '0;
                        r_wd         <= '0;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_dp_reset   <= 1'b1;
                    r_lfsr_reset <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dp_reset    = r_dp_reset;
    assign bus.lfsr_reset  = r_lfsr_reset;
    assign bus.lfsr_load   = r_lfsr_load;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.frame_end   = r_frame_end;
    assign bus.timeout_err = r_timeout_err;
    assign bus.frame_idx   = r_frame_idx;
    assign bus.sym_cnt     = r_sym_cnt;
endmodule
